// File: rtl/nonce_scheduler_if.sv
// nonce_scheduler_if: host/config and miner_core handshake bundle for nonce_scheduler.
// Optional macro NONCE_SCHED_STATS_EN adds attempts and last_latency.
interface nonce_scheduler_if #(parameter int NONCE_W = 32);
   logic start, stop, core_finished, core_correct;
   logic hash_enable, busy, done, found, exhausted, aborted, timeout_err;
   logic [NONCE_W-1:0] nonce_start, nonce_end, core_nonce, found_nonce;
`ifdef NONCE_SCHED_STATS_EN
   logic [NONCE_W-1:0] attempts;
   logic [15:0] last_latency;
`endif
   modport master (
      output start, stop, nonce_start, nonce_end, core_finished, core_correct,
      input hash_enable, core_nonce, busy, done, found, exhausted, aborted, timeout_err, found_nonce
`ifdef NONCE_SCHED_STATS_EN
      , input attempts, last_latency
`endif
   );
   modport slave (
      input start, stop, nonce_start, nonce_end, core_finished, core_correct,
      output hash_enable, core_nonce, busy, done, found, exhausted, aborted, timeout_err, found_nonce
`ifdef NONCE_SCHED_STATS_EN
      , output attempts, last_latency
`endif
   );
endinterface

// File: rtl/nonce_scheduler.sv
// nonce_scheduler: sweeps one miner_core across [nonce_start, nonce_end] until hit, exhaustion, stop or watchdog.
// Optional macro NONCE_SCHED_STATS_EN adds attempts and last_latency outputs.
module nonce_scheduler #(
   parameter int NONCE_W = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic clk,
   input logic rst,
   nonce_scheduler_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   state_t state, state_nx;
   logic [NONCE_W-1:0] cur, last, found_nonce;
   logic [15:0] wdog;
   logic stop_seen, found, exhausted, aborted, timeout_err;
   logic accept, fin, stopped, expire;
   assign accept = state == IDLE && bus.start;
   assign fin = state == WAIT && bus.core_finished;
   assign stopped = stop_seen || bus.stop;
   // Counter value one short of the limit, so DONE lands TIMEOUT_CYCLES after the pulse.
   assign expire = state == WAIT && !bus.core_finished && wdog == 16'(TIMEOUT_CYCLES - 2);
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: state_nx = bus.start ? (bus.stop ? DONE : ISSUE) : IDLE;
         ISSUE: state_nx = WAIT;
         WAIT: state_nx = fin ? ((bus.core_correct || stopped || cur == last) ? DONE : ISSUE)
                              : (expire ? DONE : WAIT);
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cur <= '0;
         last <= '0;
         wdog <= '0;
         stop_seen <= 1'b0;
         found <= 1'b0;
         exhausted <= 1'b0;
         aborted <= 1'b0;
         timeout_err <= 1'b0;
         found_nonce <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            cur <= bus.nonce_start;
            last <= bus.nonce_end;
            stop_seen <= 1'b0;
            found <= 1'b0;
            exhausted <= 1'b0;
            aborted <= bus.stop;
            timeout_err <= 1'b0;
            found_nonce <= '0;
         end
         if (state == ISSUE) begin
            wdog <= '0;
            stop_seen <= bus.stop;
         end
         if (state == WAIT) begin
            stop_seen <= stopped;
            if (!bus.core_finished) wdog <= wdog + 16'd1;
            if (expire) timeout_err <= 1'b1;
         end
         if (fin) begin
            if (bus.core_correct) begin
               found <= 1'b1;
               found_nonce <= cur;
            end else if (stopped) aborted <= 1'b1;
            else if (cur == last) exhausted <= 1'b1;
            else cur <= cur + 1'b1;
         end
      end
   end
   assign bus.hash_enable = state == ISSUE;
   assign bus.core_nonce = cur;
   assign bus.busy = state != IDLE;
   assign bus.done = state == DONE;
   assign bus.found = found;
   assign bus.exhausted = exhausted;
   assign bus.aborted = aborted;
   assign bus.timeout_err = timeout_err;
   assign bus.found_nonce = found_nonce;
`ifdef NONCE_SCHED_STATS_EN
   logic [NONCE_W-1:0] attempts;
   logic [15:0] last_latency;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         attempts <= '0;
         last_latency <= '0;
      end else begin
         if (accept) attempts <= '0;
         else if (state == ISSUE && !(&attempts)) attempts <= attempts + 1'b1;
         if (fin) last_latency <= wdog + 16'd1;
      end
   end
   assign bus.attempts = attempts;
   assign bus.last_latency = last_latency;
`endif
endmodule
